// File: rtl/mmio_cmd_pkg.sv
// mmio_cmd_pkg
// Shared types and constants for the mmio command driver:
//   mmio_op_t      - command opcodes on the cmd port
//   drv_state_t    - driver FSM states
//   MMIO_*_WIDTH   - mmio_if bus widths
//   *_ADDR         - register map of the DMA-style block this driver usually programs
//   mask_hit()     - poll completion test
package mmio_cmd_pkg;

  localparam int MMIO_ADDR_WIDTH = 16;
  localparam int MMIO_DATA_WIDTH = 64;

  localparam logic [MMIO_ADDR_WIDTH-1:0] GO_ADDR      = 16'h0050;
  localparam logic [MMIO_ADDR_WIDTH-1:0] RD_ADDR_ADDR = 16'h0052;
  localparam logic [MMIO_ADDR_WIDTH-1:0] WR_ADDR_ADDR = 16'h0054;
  localparam logic [MMIO_ADDR_WIDTH-1:0] SIZE_ADDR    = 16'h0056;
  localparam logic [MMIO_ADDR_WIDTH-1:0] DONE_ADDR    = 16'h0058;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } mmio_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    GAP      = 3'd4,
    RESP     = 3'd5
  } drv_state_t;

  // A zero mask can never hit, so such a poll always runs to its read limit.
  function automatic logic mask_hit(input logic [MMIO_DATA_WIDTH-1:0] data,
                                    input logic [MMIO_DATA_WIDTH-1:0] mask);
    return |(data & mask);
  endfunction

endpackage

// File: rtl/mmio_if.sv
// mmio_if
// Simple register-access bus between an initiator and a memory_map block.
//   mmio modport (initiator): drives wr_en, wr_addr, wr_data, rd_en, rd_addr;
//                             samples rd_data
//   regs modport (target)   : the mirror image
interface mmio_if;
  import mmio_cmd_pkg::*;

  logic                       wr_en;
  logic [MMIO_ADDR_WIDTH-1:0] wr_addr;
  logic [MMIO_DATA_WIDTH-1:0] wr_data;
  logic                       rd_en;
  logic [MMIO_ADDR_WIDTH-1:0] rd_addr;
  logic [MMIO_DATA_WIDTH-1:0] rd_data;

  modport mmio (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport regs (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/mmio_rd_tracker.sv
// mmio_rd_tracker
// Tracks an outstanding mmio read: a RD_LATENCY-deep valid shift register
// that turns the rd_en pulse into a one-cycle capture strobe in the cycle
// where rd_data is valid.
//   clk        clock
//   rst        synchronous active-low reset (drops any in-flight read)
//   i_rd_en    read strobe issued on the bus
//   o_capture  rd_data valid this cycle
module mmio_rd_tracker #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rd_en,
  output logic o_capture
);

  logic r_pipe [0:RD_LATENCY-1];

  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst) r_pipe[gi] <= 1'b0;
        else      r_pipe[gi] <= i_rd_en;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!rst) r_pipe[gi] <= 1'b0;
        else      r_pipe[gi] <= r_pipe[gi-1];
      end
    end
  end

  assign o_capture = r_pipe[RD_LATENCY-1];

endmodule

// File: rtl/mmio_cmd_driver.sv
// mmio_cmd_driver
// Initiator side of mmio_if. Takes one register command at a time (write,
// read, poll-until-set) on a valid/ready port, issues it as mmio strobes and
// returns a response on a valid/ready port.
//   clk, rst          clock, synchronous active-low reset
//   mmio              mmio_if initiator modport
//   cmd_valid/ready   command handshake
//   cmd_op            mmio_op_t (3 is reserved and answered with rsp_err)
//   cmd_addr          register address
//   cmd_data          write data, or the poll mask
//   cmd_limit         poll read limit minus one
//   rsp_valid/ready   response handshake
//   rsp_data          read data / last poll data, 0 for writes
//   rsp_timeout       poll exhausted without a mask hit
//   rsp_err           command rejected
// Build option MMIO_CMD_DRIVER_ADDR_CHECK_EN: odd addresses are rejected with
// rsp_err and never reach the bus (64-bit registers sit on even addresses).
module mmio_cmd_driver
  import mmio_cmd_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int POLL_GAP   = 4,
  parameter int TO_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  mmio_if.mmio                       mmio,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [MMIO_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [MMIO_DATA_WIDTH-1:0] cmd_data,
  input  logic [TO_WIDTH-1:0]        cmd_limit,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MMIO_DATA_WIDTH-1:0] rsp_data,
  output logic                       rsp_timeout,
  output logic                       rsp_err
);

  localparam int GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  drv_state_t r_state;
  drv_state_t w_state_next;

  mmio_op_t                   r_op;
  logic [MMIO_DATA_WIDTH-1:0] r_mask;
  logic [TO_WIDTH-1:0]        r_limit;
  logic [TO_WIDTH:0]          r_cnt;      // one bit wider so limit=all-ones cannot wrap
  logic [GAP_W-1:0]           r_gap_cnt;

  logic [MMIO_ADDR_WIDTH-1:0] r_wr_addr;
  logic [MMIO_DATA_WIDTH-1:0] r_wr_data;
  logic [MMIO_ADDR_WIDTH-1:0] r_rd_addr;
  logic [MMIO_DATA_WIDTH-1:0] r_rsp_data;
  logic                       r_rsp_timeout;
  logic                       r_rsp_err;

  logic w_wr_en;
  logic w_rd_en;
  logic w_cmd_ready;
  logic w_rsp_valid;
  logic w_accept;
  logic w_capture;
  logic w_addr_bad;
  logic w_op_bad;
  logic w_hit;
  logic w_last;
  logic w_gap_done;

`ifdef MMIO_CMD_DRIVER_ADDR_CHECK_EN
  assign w_addr_bad = cmd_addr[0];
`else
  assign w_addr_bad = 1'b0;
`endif

  assign w_op_bad   = (mmio_op_t'(cmd_op) == OP_RSVD);
  assign w_accept   = cmd_valid & w_cmd_ready;
  assign w_hit      = mask_hit(mmio.rd_data, r_mask);
  assign w_last     = (r_cnt == ({1'b0, r_limit} + {{TO_WIDTH{1'b0}}, 1'b1}));
  assign w_gap_done = (r_gap_cnt == GAP_W'(GAP_LAST));

  mmio_rd_tracker #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_tracker (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (w_rd_en),
    .o_capture (w_capture)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next state and strobes.
  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_cmd_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        // Held low during reset so nothing is accepted while rst=0.
        w_cmd_ready = rst;
        if (cmd_valid && rst) begin
          if (w_op_bad || w_addr_bad)                   w_state_next = RESP;
          else if (mmio_op_t'(cmd_op) == OP_WRITE)      w_state_next = WR;
          else                                          w_state_next = RD_ISSUE;
        end
      end
      WR: begin
        w_wr_en      = 1'b1;
        w_state_next = RESP;
      end
      RD_ISSUE: begin
        w_rd_en      = 1'b1;
        w_state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (w_capture) begin
          // A hit on the final permitted read still counts as success.
          if (r_op != OP_POLL || w_hit || w_last) w_state_next = RESP;
          else if (POLL_GAP == 0)                 w_state_next = RD_ISSUE;
          else                                    w_state_next = GAP;
        end
      end
      GAP: begin
        if (w_gap_done) w_state_next = RD_ISSUE;
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Command latch, bus address/data holding registers and response fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op          <= OP_WRITE;
      r_mask        <= '0;
      r_limit       <= '0;
      r_cnt         <= '0;
      r_gap_cnt     <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_rd_addr     <= '0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op          <= mmio_op_t'(cmd_op);
        r_mask        <= cmd_data;
        r_limit       <= cmd_limit;
        r_cnt         <= '0;
        r_rsp_data    <= '0;
        r_rsp_timeout <= 1'b0;
        r_rsp_err     <= w_op_bad | w_addr_bad;
        // Rejected commands leave the bus registers untouched.
        if (!w_op_bad && !w_addr_bad) begin
          if (mmio_op_t'(cmd_op) == OP_WRITE) begin
            r_wr_addr <= cmd_addr;
            r_wr_data <= cmd_data;
          end else begin
            r_rd_addr <= cmd_addr;
          end
        end
      end

      if (r_state == RD_ISSUE) r_cnt <= r_cnt + 1'b1;

      if (r_state == RD_WAIT && w_capture) begin
        r_rsp_data <= mmio.rd_data;
        if (r_op == OP_POLL && !w_hit && w_last) r_rsp_timeout <= 1'b1;
      end

      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                r_gap_cnt <= '0;
    end
  end

  assign mmio.wr_en   = w_wr_en;
  assign mmio.wr_addr = r_wr_addr;
  assign mmio.wr_data = r_wr_data;
  assign mmio.rd_en   = w_rd_en;
  assign mmio.rd_addr = r_rd_addr;

  assign cmd_ready   = w_cmd_ready;
  assign rsp_valid   = w_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_mmio_cmd_driver.sv
// tb_mmio_cmd_driver
// Directed bench for mmio_cmd_driver (RD_LATENCY=1, POLL_GAP=4, TO_WIDTH=16)
// with a small register-block model on mmio_if. The done register (h0058)
// reads 1 once a programmable number of reads of it has been reached.
module tb_mmio_cmd_driver;
  import mmio_cmd_pkg::*;

  localparam int GAP_CYC = 1 + 1 + 4;  // 1 + RD_LATENCY + POLL_GAP

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [15:0] cmd_limit;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_err;

  mmio_if u_mmio ();

  mmio_cmd_driver #(
    .RD_LATENCY (1),
    .POLL_GAP   (4),
    .TO_WIDTH   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mmio        (u_mmio),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_limit   (cmd_limit),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register block model ----------------
  logic [63:0] mem [0:255];
  int done_reads = 0;
  int done_base  = 0;
  int done_after = 0;   // 0: done never rises

  always @(posedge clk) begin
    if (u_mmio.wr_en) mem[u_mmio.wr_addr[7:0]] <= u_mmio.wr_data;
    if (u_mmio.rd_en) begin
      if (u_mmio.rd_addr == DONE_ADDR) begin
        done_reads <= done_reads + 1;
        u_mmio.rd_data <= (done_after != 0 && (done_reads + 1 - done_base) >= done_after)
                          ? 64'd1 : 64'd0;
      end else begin
        u_mmio.rd_data <= mem[u_mmio.rd_addr[7:0]];
      end
    end else begin
      u_mmio.rd_data <= 64'hA5A5_5A5A_A5A5_5A5A;  // filler to expose mistimed capture
    end
  end

  // ---------------- bus monitor ----------------
  int          wr_total = 0;
  int          rd_total = 0;
  int          rsp_total = 0;
  int          both_total = 0;
  int          rd_hist [0:511];
  logic [15:0] last_wr_addr;
  logic [63:0] last_wr_data;
  logic [15:0] last_rd_addr;

  always @(negedge clk) begin
    if (u_mmio.wr_en) begin
      wr_total     <= wr_total + 1;
      last_wr_addr <= u_mmio.wr_addr;
      last_wr_data <= u_mmio.wr_data;
    end
    if (u_mmio.rd_en) begin
      rd_hist[rd_total % 512] <= cyc;
      rd_total     <= rd_total + 1;
      last_rd_addr <= u_mmio.rd_addr;
    end
    if (rsp_valid) rsp_total <= rsp_total + 1;
    if (u_mmio.wr_en && u_mmio.rd_en) both_total <= both_total + 1;
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no event within cycle budget (cycle %0d)", name, cyc);
  endtask

  task automatic wait_accept(output int acc);
    bit ok = 0;
    acc = cyc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    acc = cyc;
    if (!ok) bound_fail("accept");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int got);
    bit ok = 0;
    got = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    got = cyc;
    if (!ok) bound_fail("rsp_valid");
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [15:0] addr,
                           input logic [63:0] data, input logic [15:0] limit);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_limit = limit;
    cmd_valid = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [63:0] data;
    logic [15:0] limit;
    int          done_after;
    logic [63:0] exp_data;
    logic        exp_to;
    logic        exp_err;
    int          exp_wr;
    int          exp_rd;
    int          exp_lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(input string nm, input logic [1:0] op, input logic [15:0] a,
                              input logic [63:0] d, input logic [15:0] lim, input int da,
                              input logic [63:0] ed, input logic eto, input logic eerr,
                              input int ewr, input int erd, input int elat);
    vec_t v;
    v.name = nm; v.op = op; v.addr = a; v.data = d; v.limit = lim; v.done_after = da;
    v.exp_data = ed; v.exp_to = eto; v.exp_err = eerr;
    v.exp_wr = ewr; v.exp_rd = erd; v.exp_lat = elat;
    return v;
  endfunction

  int acc, got, wr0, rd0, rsp0, hs;

  initial begin
    // Poll latency: last read at accept+1+(n-1)*6, response two cycles later.
    vecs[0]  = mk("wr_size",   2'd0, SIZE_ADDR,    64'd32,                 16'd0,  0, 64'd0,  0, 0, 1, 0, 2);
    vecs[1]  = mk("rd_size",   2'd1, SIZE_ADDR,    64'd0,                  16'd0,  0, 64'd32, 0, 0, 0, 1, 3);
    vecs[2]  = mk("wr_rdaddr", 2'd0, RD_ADDR_ADDR, 64'h1234_5678_9ABC_DEF0, 16'd0, 0, 64'd0,  0, 0, 1, 0, 2);
    vecs[3]  = mk("rd_rdaddr", 2'd1, RD_ADDR_ADDR, 64'd0,                  16'd0,  0, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 1, 3);
    vecs[4]  = mk("wr_wraddr", 2'd0, WR_ADDR_ADDR, 64'h0000_0000_0000_1000, 16'd0, 0, 64'd0,  0, 0, 1, 0, 2);
    vecs[5]  = mk("poll_hit4", 2'd2, DONE_ADDR,    64'd1,                  16'd15, 4, 64'd1,  0, 0, 0, 4, 21);
    vecs[6]  = mk("poll_to3",  2'd2, DONE_ADDR,    64'd1,                  16'd2,  0, 64'd0,  1, 0, 0, 3, 15);
    vecs[7]  = mk("poll_m0",   2'd2, DONE_ADDR,    64'd0,                  16'd1,  1, 64'd1,  1, 0, 0, 2, 9);
    vecs[8]  = mk("poll_l0to", 2'd2, DONE_ADDR,    64'd1,                  16'd0,  0, 64'd0,  1, 0, 0, 1, 3);
    vecs[9]  = mk("poll_l0ht", 2'd2, DONE_ADDR,    64'd1,                  16'd0,  1, 64'd1,  0, 0, 0, 1, 3);
    vecs[10] = mk("op_rsvd",   2'd3, GO_ADDR,      64'd5,                  16'd0,  0, 64'd0,  0, 1, 0, 0, 1);
`ifdef MMIO_CMD_DRIVER_ADDR_CHECK_EN
    vecs[11] = mk("wr_odd",    2'd0, 16'h0051,     64'd7,                  16'd0,  0, 64'd0,  0, 1, 0, 0, 1);
    vecs[12] = mk("rd_odd",    2'd1, 16'h0051,     64'd0,                  16'd0,  0, 64'd0,  0, 1, 0, 0, 1);
`else
    vecs[11] = mk("wr_odd",    2'd0, 16'h0051,     64'd7,                  16'd0,  0, 64'd0,  0, 0, 1, 0, 2);
    vecs[12] = mk("rd_odd",    2'd1, 16'h0051,     64'd0,                  16'd0,  0, 64'd7,  0, 0, 0, 1, 3);
`endif
    vecs[13] = mk("wr_go",     2'd0, GO_ADDR,      64'd1,                  16'd0,  0, 64'd0,  0, 0, 1, 0, 2);

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
    cmd_limit = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("reset wr_en", {63'd0, u_mmio.wr_en}, 64'd0);
    chk("reset rd_en", {63'd0, u_mmio.rd_en}, 64'd0);
    chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset rsp_flags", {62'd0, rsp_timeout, rsp_err}, 64'd0);
    chk("reset rsp_data", rsp_data, 64'd0);
    chk("reset wr_addr", {48'd0, u_mmio.wr_addr}, 64'd0);
    chk("reset wr_data", u_mmio.wr_data, 64'd0);
    chk("reset rd_addr", {48'd0, u_mmio.rd_addr}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < NV; v++) begin
      wr0 = wr_total; rd0 = rd_total;
      done_base  = done_reads;
      done_after = vecs[v].done_after;
      drive_cmd(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].limit);
      wait_accept(acc);
      wait_rsp(got);
      chk({vecs[v].name, " latency"}, 64'(got - acc), 64'(vecs[v].exp_lat));
      chk({vecs[v].name, " rsp_data"}, rsp_data, vecs[v].exp_data);
      chk({vecs[v].name, " rsp_timeout"}, {63'd0, rsp_timeout}, {63'd0, vecs[v].exp_to});
      chk({vecs[v].name, " rsp_err"}, {63'd0, rsp_err}, {63'd0, vecs[v].exp_err});
      chk({vecs[v].name, " wr_en pulses"}, 64'(wr_total - wr0), 64'(vecs[v].exp_wr));
      chk({vecs[v].name, " rd_en pulses"}, 64'(rd_total - rd0), 64'(vecs[v].exp_rd));
      if (vecs[v].exp_wr != 0) begin
        chk({vecs[v].name, " wr_addr"}, {48'd0, last_wr_addr}, {48'd0, vecs[v].addr});
        chk({vecs[v].name, " wr_data"}, last_wr_data, vecs[v].data);
      end
      if (vecs[v].exp_rd != 0)
        chk({vecs[v].name, " rd_addr"}, {48'd0, last_rd_addr}, {48'd0, vecs[v].addr});
      for (int j = rd0 + 1; j < rd_total; j++)
        chk({vecs[v].name, " poll spacing"}, 64'(rd_hist[j % 512] - rd_hist[(j - 1) % 512]),
            64'(GAP_CYC));
      $display("txn %-10s op=%0d addr=%h lat=%0d rsp_data=%h to=%0b err=%0b wr=%0d rd=%0d",
               vecs[v].name, vecs[v].op, vecs[v].addr, got - acc, rsp_data, rsp_timeout,
               rsp_err, wr_total - wr0, rd_total - rd0);
      @(posedge clk); #1;
    end

    // ---------------- response back-pressure + back-to-back command ----------------
    rsp_ready = 1'b0;
    drive_cmd(2'd1, RD_ADDR_ADDR, 64'd0, 16'd0);
    wait_accept(acc);
    drive_cmd(2'd0, WR_ADDR_ADDR, 64'h0000_0000_0000_2000, 16'd0);  // waits in cmd port
    wait_rsp(got);
    chk("bp latency", 64'(got - acc), 64'd3);
    for (int i = 0; i < 10; i++) begin
      chk("bp rsp_valid held", {63'd0, rsp_valid}, 64'd1);
      chk("bp rsp_data stable", rsp_data, 64'h1234_5678_9ABC_DEF0);
      chk("bp cmd_ready low", {63'd0, cmd_ready}, 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    hs = cyc;
    $display("txn bp_read   handshake at cycle %0d after 10 stalled cycles", hs);
    wr0 = wr_total;
    wait_accept(acc);
    chk("bp next accept cycle", 64'(acc - hs), 64'd1);
    wait_rsp(got);
    chk("bp next latency", 64'(got - acc), 64'd2);
    chk("bp next rsp_data", rsp_data, 64'd0);
    chk("bp next wr_en pulses", 64'(wr_total - wr0), 64'd1);
    $display("txn bp_write  accepted at cycle %0d rsp at %0d", acc, got);
    @(posedge clk); #1;

    // ---------------- reset while in GAP ----------------
    done_base = done_reads; done_after = 0;
    rd0 = rd_total;
    drive_cmd(2'd2, DONE_ADDR, 64'd1, 16'd15);
    wait_accept(acc);
    begin
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (rd_total - rd0 >= 2) begin
          ok = 1;
          break;
        end
      end
      if (!ok) bound_fail("gap reads");
    end
    // rd_total updates at this negedge, so the 2nd rd_en was in the previous
    // cycle; one more cycle lands in GAP (rd, wait, gap...).
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("gaprst cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("gaprst strobes", {62'd0, u_mmio.wr_en, u_mmio.rd_en}, 64'd0);
    chk("gaprst rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("gaprst rsp_flags", {62'd0, rsp_timeout, rsp_err}, 64'd0);
    chk("gaprst rsp_data", rsp_data, 64'd0);
    chk("gaprst wr_addr", {48'd0, u_mmio.wr_addr}, 64'd0);
    chk("gaprst rd_addr", {48'd0, u_mmio.rd_addr}, 64'd0);
    chk("gaprst wr_data", u_mmio.wr_data, 64'd0);
    rst = 1'b1;
    rd0 = rd_total; rsp0 = rsp_total;
    repeat (30) @(negedge clk);
    chk("gaprst no rd after reset", 64'(rd_total - rd0), 64'd0);
    chk("gaprst no rsp after reset", 64'(rsp_total - rsp0), 64'd0);
    chk("gaprst idle ready", {63'd0, cmd_ready}, 64'd1);
    $display("txn gap_reset aborted poll, %0d reads / %0d responses afterwards",
             rd_total - rd0, rsp_total - rsp0);

    chk("wr_en and rd_en never together", 64'(both_total), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
